// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines and a single-beat memory port.
// Optional statistics counters (hit_count, miss_count) are built when DCACHE_STATS_EN is defined.
module dcache #(
    parameter int INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic        miss,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*4];

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               req, hit, ack_last;
    logic               data_we, tag_we;
    logic [INDEX_W+1:0] data_waddr;
    logic [31:0]        data_wdata;
    logic               unused_addr_bits;

    assign offset           = addr[3:2];
    assign index            = addr[3+INDEX_W:4];
    assign tag              = addr[31:4+INDEX_W];
    assign unused_addr_bits = ^addr[1:0];

    assign req      = read_enable || write_enable;
    assign hit      = valid_q[index] && (tag_mem[index] == tag) && (state_q == IDLE);
    // Gating with rstn keeps the stall deasserted while reset is held.
    assign miss     = rstn && req && !hit;
    assign rdata    = hit ? data_mem[{index, offset}] : '0;
    assign ack_last = mem_ack && (beat_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        data_we    = 1'b0;
        data_waddr = {index, offset};
        data_wdata = wdata;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = (valid_q[index] && dirty_q[index]) ? WB : FILL;
                end else if (write_enable) begin
                    data_we        = 1'b1;
                    dirty_d[index] = 1'b1;
                end
            end
            WB: begin
                mem_wr_req = 1'b1;
                mem_addr   = {tag_mem[index], index, beat_q, 2'b00};
                mem_wdata  = data_mem[{index, beat_q}];
                if (mem_ack) begin
                    beat_d = beat_q + 2'd1;
                    if (ack_last) state_d = FILL;
                end
            end
            FILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = {tag, index, beat_q, 2'b00};
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_waddr = {index, beat_q};
                    data_wdata = mem_rdata;
                    beat_d     = beat_q + 2'd1;
                    if (ack_last) begin
                        state_d        = IDLE;
                        valid_d[index] = 1'b1;
                        dirty_d[index] = 1'b0;
                        tag_we         = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Line storage carries no reset; valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
        if (tag_we)  tag_mem[index]       <= tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        replay_q, replay_d;

    // The hit that completes a refilled request was already counted as a miss.
    always_comb begin
        replay_d     = (state_q == FILL) && ack_last;
        hit_count_d  = hit_count_q + {31'd0, (req && hit && !replay_q)};
        miss_count_d = miss_count_q + {31'd0, ((state_q == IDLE) && miss)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            replay_q     <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            replay_q     <= replay_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, reset-during-refill sequence,
// and randomized traffic checked against a flat-memory / per-index tag model.
module tb_dcache;

    localparam int INDEX_W = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr, wdata, rdata;
    logic        write_enable, read_enable, miss;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack   = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic        pulse;
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_miss;
        logic [31:0] exp_rd;
        int          exp_beats;
    } vec_t;

    beat_t       beat_log[$];
    logic [31:0] bmem [logic [31:0]];
    int          cnt = 0;
    logic        idle_pulse;

    dcache #(.INDEX_W(INDEX_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .miss        (miss),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : a;
    endfunction

    // Backing memory: unwritten words read back as their own address; ack two cycles after a request.
    always @(negedge clk) begin
        if (!rstn) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else if (mem_rd_req || mem_wr_req) begin
            cnt++;
            if (cnt == 2) begin
                mem_ack = 1'b1;
                beat_log.push_back('{wr: mem_wr_req, a: mem_addr, d: mem_wdata});
                if (mem_wr_req) bmem[mem_addr] = mem_wdata;
                else            mem_rdata      = bmem_rd(mem_addr);
            end
        end else begin
            cnt     = 0;
            mem_ack = idle_pulse;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd,
                          output logic m, output logic [31:0] rd, output int nb, output int base);
        int cyc;
        @(negedge clk);
        base         = beat_log.size();
        addr         = a;
        wdata        = wd;
        write_enable = we;
        read_enable  = re;
        #1;
        m   = miss;
        cyc = 0;
        while (miss && cyc < 300) begin
            chk("req_exclusive", {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("miss_cleared", {31'd0, miss}, 32'd0);
        rd = rdata;
        nb = beat_log.size() - base;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        $display("access we=%0b re=%0b addr=%h wdata=%h first_miss=%0b rdata=%h beats=%0d",
                 we, re, a, wd, m, rd, nb);
    endtask

    task automatic idle_ack_pulse();
        @(posedge clk);
        #1 idle_pulse = 1'b1;
        @(negedge clk);
        #1 idle_pulse = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ack_miss", {31'd0, miss}, 32'd0);
        chk("idle_ack_rd_req", {31'd0, mem_rd_req}, 32'd0);
        chk("idle_ack_wr_req", {31'd0, mem_wr_req}, 32'd0);
        chk("idle_ack_mem_addr", mem_addr, 32'd0);
        $display("idle mem_ack pulse applied");
    endtask

    vec_t        vecs[8];
    beat_t       exp_q[$];
    logic        m;
    logic [31:0] rd;
    int          nb, base, cyc;
    logic        ref_valid[4];
    logic [19:0] ref_tag[4];
    logic        ref_dirty[4];
    logic [31:0] ref_mem [logic [31:0]];
    logic [7:0]  idx_tab[4];
    logic [19:0] tag_tab[4];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a;
    endfunction

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0010, 4};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'hDEADBEEF,  1'b0, 32'h0,         0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h0,         1'b0, 32'hDEADBEEF,  0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_1014, 32'h0,         1'b1, 32'h0000_1014, 8};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_1014, 32'h0,         1'b0, 32'h0000_1014, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_1014, 32'h0,         1'b0, 32'h0000_1014, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_1018, 32'hCAFEF00D,  1'b0, 32'h0000_1018, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_1018, 32'h0,         1'b0, 32'hCAFEF00D,  0};
        idx_tab = '{8'h00, 8'h01, 8'h02, 8'hFF};
        tag_tab = '{20'h00000, 20'h00001, 20'hABCDE, 20'hFFFFF};

        rstn = 1'b1; addr = '0; wdata = '0; write_enable = 1'b0; read_enable = 1'b0; idle_pulse = 1'b0;
        #2 rstn = 1'b0;
        addr = 32'h10;
        read_enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_miss", {31'd0, miss}, 32'd0);
        chk("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        chk("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        read_enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pulse) idle_ack_pulse();
            access(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, m, rd, nb, base);
            chk($sformatf("vec%0d_miss", i), {31'd0, m}, {31'd0, vecs[i].exp_miss});
            if (vecs[i].re) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_beats", i), nb, vecs[i].exp_beats);
            if (i == 0 && nb == 4) begin
                for (int b = 0; b < 4; b++) begin
                    chk("fill0_kind", {31'd0, beat_log[base+b].wr}, 32'd0);
                    chk("fill0_addr", beat_log[base+b].a, 32'h10 + 32'(4*b));
                end
            end
            if (i == 3 && nb == 8) begin
                for (int b = 0; b < 4; b++) begin
                    chk("wb_kind", {31'd0, beat_log[base+b].wr}, 32'd1);
                    chk("wb_addr", beat_log[base+b].a, 32'h10 + 32'(4*b));
                    chk("wb_data", beat_log[base+b].d, (b == 1) ? 32'hDEADBEEF : 32'h10 + 32'(4*b));
                    chk("refill_kind", {31'd0, beat_log[base+4+b].wr}, 32'd0);
                    chk("refill_addr", beat_log[base+4+b].a, 32'h1010 + 32'(4*b));
                end
            end
`ifdef DCACHE_STATS_EN
            if (i == 4) begin
                chk("stats_hit_count", hit_count, 32'd3);
                chk("stats_miss_count", miss_count, 32'd2);
            end
`endif
        end

        // Reset while the refill of 0x2010 is on beat 2 (after the dirty 0x1010 line is written back).
        @(negedge clk);
        base        = beat_log.size();
        addr        = 32'h2014;
        read_enable = 1'b1;
        cyc         = 0;
        while ((beat_log.size() - base) < 6 && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("midfill_acks", beat_log.size() - base, 32'd6);
        @(posedge clk);
        #2;
        chk("midfill_rd_req", {31'd0, mem_rd_req}, 32'd1);
        chk("midfill_addr", mem_addr, 32'h2018);
        rstn = 1'b0;
        #1;
        chk("midfill_rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        chk("midfill_rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
        chk("midfill_rst_miss", {31'd0, miss}, 32'd0);
        chk("midfill_rst_addr", mem_addr, 32'd0);
        $display("reset asserted during refill beat 2");
        @(negedge clk);
        read_enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        access(1'b0, 1'b1, 32'h1014, 32'h0, m, rd, nb, base);
        chk("post_rst_miss", {31'd0, m}, 32'd1);
        chk("post_rst_beats", nb, 32'd4);
        chk("post_rst_rdata", rd, 32'h1014);
        if (nb > 0) begin
            chk("post_rst_kind", {31'd0, beat_log[base].wr}, 32'd0);
            chk("post_rst_addr", beat_log[base].a, 32'h1010);
        end
        access(1'b0, 1'b1, 32'h1018, 32'h0, m, rd, nb, base);
        chk("post_rst_wb_data", rd, 32'hCAFEF00D);
        chk("post_rst_hit_beats", nb, 32'd0);

        // Randomized traffic against a model of memory contents plus per-index tag/dirty state.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        ref_mem = bmem;
        for (int k = 0; k < 4; k++) begin
            ref_valid[k] = 1'b0;
            ref_tag[k]   = '0;
            ref_dirty[k] = 1'b0;
        end
        for (int t = 0; t < 250; t++) begin
            int          k, op;
            logic [19:0] tg;
            logic [31:0] a, wd, line_base, victim_base, exp_rd;
            logic        we, re, exp_hit;
            k  = $urandom_range(0, 3);
            tg = tag_tab[$urandom_range(0, 3)];
            op = $urandom_range(0, 2);
            we = (op != 0);
            re = (op != 1);
            wd = $urandom;
            a  = {tg, idx_tab[k], 2'($urandom_range(0, 3)), 2'b00};
            line_base   = {tg, idx_tab[k], 4'h0};
            victim_base = {ref_tag[k], idx_tab[k], 4'h0};
            exp_hit = ref_valid[k] && (ref_tag[k] == tg);
            exp_rd  = ref_rd(a);
            exp_q.delete();
            if (!exp_hit) begin
                if (ref_valid[k] && ref_dirty[k])
                    for (int b = 0; b < 4; b++)
                        exp_q.push_back('{1'b1, victim_base + 32'(4*b), ref_rd(victim_base + 32'(4*b))});
                for (int b = 0; b < 4; b++)
                    exp_q.push_back('{1'b0, line_base + 32'(4*b), 32'h0});
            end
            access(we, re, a, wd, m, rd, nb, base);
            chk("rand_miss", {31'd0, m}, {31'd0, !exp_hit});
            if (re) chk("rand_rdata", rd, exp_rd);
            chk("rand_beats", nb, exp_q.size());
            if (nb == exp_q.size()) begin
                for (int b = 0; b < nb; b++) begin
                    chk("rand_beat_kind", {31'd0, beat_log[base+b].wr}, {31'd0, exp_q[b].wr});
                    chk("rand_beat_addr", beat_log[base+b].a, exp_q[b].a);
                    if (exp_q[b].wr) chk("rand_beat_data", beat_log[base+b].d, exp_q[b].d);
                end
            end
            if (!exp_hit) begin
                ref_valid[k] = 1'b1;
                ref_tag[k]   = tg;
                ref_dirty[k] = 1'b0;
            end
            if (we) begin
                ref_mem[a]   = wd;
                ref_dirty[k] = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
